// File: rtl/cpu_pkg.sv
// Shared types and helpers for the CPU control path: FSM encoding,
// forward-select codes and a saturating counter increment.
package cpu_pkg;

  localparam int RW = 5;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_DRAIN = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  // Counters of any width up to 64 bits share this; max is the all-ones value of that width.
  function automatic logic [63:0] sat_inc(input logic [63:0] value, input logic [63:0] max);
    if (value >= max) begin
      return max;
    end else begin
      return value + 64'd1;
    end
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Operand forwarding select for one EX source: MEM result beats WB result,
// and register 0 never forwards.
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int RW = cpu_pkg::RW
) (
  input  logic [RW-1:0] src,
  input  logic [RW-1:0] mem_rd,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] wb_rd,
  input  logic          wb_regwrite,
  output logic [1:0]    sel
);

  // Priority match against the in-flight destinations
  always_comb begin
    sel = FWD_RF;
    if (mem_regwrite && (mem_rd != {RW{1'b0}}) && (mem_rd == src)) begin
      sel = FWD_MEM;
    end else if (wb_regwrite && (wb_rd != {RW{1'b0}}) && (wb_rd == src)) begin
      sel = FWD_WB;
    end else begin
      sel = FWD_RF;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and run-control unit: stall/flush/forward decisions, halt drain
// sequencing with button restart, and saturating performance counters.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int RW = cpu_pkg::RW,
  parameter int CW = 32,
  parameter int SW = 16
) (
  input  logic          clk,
  input  logic          RST,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_rs_used,
  input  logic          id_rt_used,
  input  logic          id_halt,
  input  logic [RW-1:0] ex_rs,
  input  logic [RW-1:0] ex_rt,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_regwrite,
  input  logic          ex_memread,
  input  logic          ex_redirect,
  input  logic [RW-1:0] mem_rd,
  input  logic          mem_regwrite,
  input  logic [RW-1:0] wb_rd,
  input  logic          wb_regwrite,
  input  logic          wb_halt,
  input  logic          run_go,
  output logic          pc_stall,
  output logic          ifid_stall,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          pipe_en,
  output logic          halted,
  output logic [CW-1:0] cycle_cnt,
  output logic [SW-1:0] stall_cnt,
  output logic [SW-1:0] flush_cnt
);

  localparam logic [63:0] CMAX = 64'({CW{1'b1}});
  localparam logic [63:0] SMAX = 64'({SW{1'b1}});

  state_t state_r;
  logic   lu_s;
  logic   stall_ev_s;
  logic   flush_ev_s;

  // Load-use: the EX load's destination is a source the ID instruction really reads
  always_comb begin
    lu_s = ex_memread && ex_regwrite && (ex_rd != {RW{1'b0}}) &&
           ((id_rs_used && (ex_rd == id_rs)) || (id_rt_used && (ex_rd == id_rt)));
  end

  // Per-state stall/flush decode; redirect squashes ID so it outranks load-use and halt
  always_comb begin
    pc_stall   = 1'b0;
    ifid_stall = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (ex_redirect) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (lu_s) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end else if (id_halt) begin
          pc_stall   = 1'b1;
          ifid_flush = 1'b1;
        end else begin
          pc_stall   = 1'b0;
        end
      end
      ST_DRAIN: begin
        pc_stall   = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = ex_redirect;
      end
      ST_HALT: begin
        pc_stall   = 1'b1;
      end
      default: begin
        pc_stall   = 1'b0;
      end
    endcase
  end

  // Counted events only occur in RUN; a redirect while draining is not counted
  always_comb begin
    stall_ev_s = (state_r == ST_RUN) && !ex_redirect && lu_s;
    flush_ev_s = (state_r == ST_RUN) && ex_redirect;
  end

  fwd_sel #(.RW(RW)) u_fwd_a (
    .src(ex_rs), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(fwd_a)
  );

  fwd_sel #(.RW(RW)) u_fwd_b (
    .src(ex_rt), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(fwd_b)
  );

  // Run-control FSM with registered pipe_en/halted
  always_ff @(posedge clk) begin
    if (RST) begin
      state_r <= ST_RUN;
      pipe_en <= 1'b1;
      halted  <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (!ex_redirect && !lu_s && id_halt) begin
            state_r <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (wb_halt) begin
            state_r <= ST_HALT;
            pipe_en <= 1'b0;
            halted  <= 1'b1;
          end
        end
        ST_HALT: begin
          if (run_go) begin
            state_r <= ST_RUN;
            pipe_en <= 1'b1;
            halted  <= 1'b0;
          end
        end
        default: begin
          state_r <= ST_RUN;
          pipe_en <= 1'b1;
          halted  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating performance counters, cleared only by reset
  always_ff @(posedge clk) begin
    if (RST) begin
      cycle_cnt <= {CW{1'b0}};
      stall_cnt <= {SW{1'b0}};
      flush_cnt <= {SW{1'b0}};
    end else begin
      if (state_r != ST_HALT) begin
        cycle_cnt <= CW'(sat_inc(64'(cycle_cnt), CMAX));
      end
      if (stall_ev_s) begin
        stall_cnt <= SW'(sat_inc(64'(stall_cnt), SMAX));
      end
      if (flush_ev_s) begin
        flush_cnt <= SW'(sat_inc(64'(flush_cnt), SMAX));
      end
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Hazard and run-control unit for the 5-stage pipelined CPU top (`i9_7980XE`).
- Each cycle it decides stalls, flushes and forwarding selects for the IF/ID/EX/MEM/WB datapath.
- It sequences the halt (syscall) drain-and-stop and the restart from a board button.
- It keeps performance counters that the top-level display mux shows on LEDs and SEG/AN.

## Interface
Parameters:
- `RW`, default 5, register-index width.
- `CW`, default 32, cycle-counter width.
- `SW`, default 16, stall- and flush-counter width.

Ports:
- `clk` in 1: system clock.
- `RST` in 1: synchronous, active-high reset.
- `id_rs`, `id_rt` in RW: source registers of the instruction in ID.
- `id_rs_used`, `id_rt_used` in 1: the ID instruction actually reads that source.
- `id_halt` in 1: the ID instruction is a halting syscall.
- `ex_rs`, `ex_rt` in RW: source registers of the instruction in EX.
- `ex_rd` in RW; `ex_regwrite`, `ex_memread` in 1: destination and control of the EX instruction.
- `ex_redirect` in 1: taken branch or jump resolved in EX.
- `mem_rd` in RW; `mem_regwrite` in 1: destination and write enable in MEM.
- `wb_rd` in RW; `wb_regwrite` in 1: destination and write enable in WB.
- `wb_halt` in 1: the halt instruction is retiring in WB.
- `run_go` in 1: restart request, a debounced one-cycle pulse.
- `pc_stall`, `ifid_stall` out 1: hold PC and the IF/ID register.
- `ifid_flush`, `idex_flush` out 1: load a bubble into IF/ID and ID/EX.
- `fwd_a`, `fwd_b` out 2: EX operand select. 00 = register file, 10 = MEM result, 01 = WB result.
- `pipe_en` out 1: global pipeline-register enable.
- `halted` out 1: FSM is in HALT.
- `cycle_cnt` out CW, `stall_cnt` out SW, `flush_cnt` out SW: performance counters.

## Operation
FSM states: RUN, DRAIN, HALT.

Detection terms:
- A register index of 0 never matches in any comparison below.
- `lu` (load-use) = `ex_memread` && `ex_regwrite` && `ex_rd`!=0 && ((`id_rs_used` && `ex_rd`==`id_rs`) || (`id_rt_used` && `ex_rd`==`id_rt`)).

RUN state, in priority order:
1. `ex_redirect`: `ifid_flush`=1 and `idex_flush`=1, no stall, `flush_cnt`+1. The redirect overrides `lu` and `id_halt` in the same cycle, because the ID instruction is squashed.
2. Else if `lu`: `pc_stall`=1, `ifid_stall`=1, `idex_flush`=1, `stall_cnt`+1.
3. Else if `id_halt`: `pc_stall`=1 and `ifid_flush`=1. Next state is DRAIN, because the halt advances into EX.
4. Else all control outputs are 0.

DRAIN state:
- Every cycle: `pc_stall`=1 and `ifid_flush`=1, so bubbles are fed behind the halt.
- `ex_redirect` is still honoured for `idex_flush` but is not counted.
- `wb_halt`=1 moves to HALT next cycle.

HALT state:
- `pipe_en`=0, `pc_stall`=1, `halted`=1.
- `run_go`=1 moves to RUN next cycle.

Other rules:
- `run_go` is ignored outside HALT.
- Forwarding is active in all states and is independent of the stall logic.
  - `fwd_a`=10 if `mem_regwrite` && `mem_rd`!=0 && `mem_rd`==`ex_rs`.
  - Else `fwd_a`=01 if `wb_regwrite` && `wb_rd`!=0 && `wb_rd`==`ex_rs`.
  - Else `fwd_a`=00.
  - `fwd_b` follows the same rules using `ex_rt`.
  - MEM wins when MEM and WB both match.
- Counters:
  - `cycle_cnt` increments every cycle the state is not HALT.
  - All counters saturate at all-ones and never wrap.
  - All counters hold their values across HALT and run_go and are cleared only by RST.
- Reset (`RST`=1 at a clock edge):
  - State goes to RUN and all counters to 0.
  - Combinational outputs then follow the RUN rules.
  - `pipe_en`=1, `halted`=0.
  - Reset in DRAIN or HALT aborts that state immediately.

## Timing
- Stall, flush and fwd outputs are combinational from the inputs and the current state, and are valid in the same cycle.
- State, `halted`, `pipe_en` and the counters are registered. Their change is visible the cycle after the qualifying event.
- Load-use costs exactly 1 bubble cycle; the next cycle `lu` is 0 because the load has moved to MEM.
- Halt latency: halt in ID at cycle t gives DRAIN from t+1. `wb_halt` arrives at t+3, and `halted`=1 at t+4.
- `run_go` seen at cycle t gives `pipe_en`=1 at t+1.

## Structure
- Shared package `cpu_pkg`:
  - FSM state encoding `ST_RUN`/`ST_DRAIN`/`ST_HALT`.
  - Forward-select constants `FWD_RF`=00, `FWD_MEM`=10, `FWD_WB`=01.
  - `RW`.
- One sub-module, `fwd_sel`: combinational, one instance per operand, taking the source index plus the MEM/WB destinations and write enables.
- Counters are inline, with a shared saturating-increment function in `cpu_pkg`.

## Test plan
- Reset: `RST` high for 2 cycles → counters 0, `pipe_en`=1, `halted`=0, all flush/stall outputs 0.
- Load-use: `ex_memread`=1, `ex_rd`=8, `id_rs`=8, `id_rs_used`=1 → `pc_stall`/`ifid_stall`/`idex_flush`=1 for one cycle, `stall_cnt`=1. With `ex_rd`=0 → no stall.
- Redirect + load-use in the same cycle → only `ifid_flush` and `idex_flush`, `flush_cnt`=1, `stall_cnt` unchanged.
- Forwarding: `mem_rd`=`wb_rd`=5 (both writing), `ex_rs`=5, `ex_rt`=3 → `fwd_a`=10, `fwd_b`=00. MEM write disabled → `fwd_a`=01.
- Halt sequence: `id_halt` at t, `wb_halt` at t+3 → `halted`=1 at t+4, `cycle_cnt` frozen. `run_go` → RUN next cycle with the counter resuming.
- Saturation / reset mid-HALT: preload `stall_cnt` near max → holds at 16'hFFFF. `RST` during HALT → RUN and counters 0.
